// File: rtl/alu_pkg.sv
// Shared op codes, FSM encoding and helpers for the alu_arbiter slice.
package alu_pkg;

   localparam logic [5:0] OP_ADD  = 6'd0;
   localparam logic [5:0] OP_SLL  = 6'd1;
   localparam logic [5:0] OP_SLT  = 6'd2;
   localparam logic [5:0] OP_SLTU = 6'd3;
   localparam logic [5:0] OP_XOR  = 6'd4;
   localparam logic [5:0] OP_SRL  = 6'd5;
   localparam logic [5:0] OP_OR   = 6'd6;
   localparam logic [5:0] OP_AND  = 6'd7;
   localparam logic [5:0] OP_SRA  = 6'd8;
   localparam logic [5:0] OP_SUB  = 6'd9;
   localparam logic [5:0] OP_MAX  = 6'd9;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_e;

   function automatic logic is_shift(logic [5:0] op);
      return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
   endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bundle between NREQ requesters and the shared ALU arbiter.
interface alu_arbiter_if #(
   parameter int NREQ = 4,
   parameter int IDW  = 2
);
   logic [NREQ-1:0]    req_valid;
   logic [NREQ-1:0]    req_ready;
   logic [6*NREQ-1:0]  req_op;
   logic [32*NREQ-1:0] req_rv1;
   logic [32*NREQ-1:0] req_rv2;
   logic               rsp_valid;
   logic               rsp_ready;
   logic [IDW-1:0]     rsp_id;
   logic [31:0]        rsp_data;
   logic               rsp_err;

   modport master (
      output req_valid, req_op, req_rv1, req_rv2, rsp_ready,
      input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_err
   );

   modport slave (
      input  req_valid, req_op, req_rv1, req_rv2, rsp_ready,
      output req_ready, rsp_valid, rsp_id, rsp_data, rsp_err
   );
endinterface

// File: rtl/alu_arbiter_alu32.sv
// Combinational 32-bit ALU; undefined op codes produce zero.
module alu32
   import alu_pkg::*;
(
   input  logic [5:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] y
);

   // Shifts use the full b; the caller is responsible for masking the amount.
   always_comb begin
      y = '0;
      case (op)
         OP_ADD:  y = a + b;
         OP_SLL:  y = a << b;
         OP_SLT:  y = {31'd0, $signed(a) < $signed(b)};
         OP_SLTU: y = {31'd0, a < b};
         OP_XOR:  y = a ^ b;
         OP_SRL:  y = a >> b;
         OP_OR:   y = a | b;
         OP_AND:  y = a & b;
         OP_SRA:  y = 32'($signed(a) >>> b);
         OP_SUB:  y = a - b;
         default: y = '0;
      endcase
   end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one alu32 between NREQ requesters with a tagged, registered response.
// ALU_ARB_RR_EN selects round-robin arbitration; otherwise lowest index wins.
module alu_arbiter
   import alu_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int IDW  = 2
) (
   input  logic          clk,
   input  logic          reset_n,
   alu_arbiter_if.slave  bus,
   output logic          busy
);

   state_e         state_q, state_d;
   logic [5:0]     op_q, op_d;
   logic [31:0]    rv1_q, rv1_d;
   logic [31:0]    rv2_q, rv2_d;
   logic [31:0]    data_q, data_d;
   logic [IDW-1:0] id_q, id_d;
   logic           vld_q, vld_d;
   logic           err_q, err_d;
`ifdef ALU_ARB_RR_EN
   logic [IDW-1:0] last_q, last_d;
`endif

   logic [5:0]     op_arr  [NREQ];
   logic [31:0]    rv1_arr [NREQ];
   logic [31:0]    rv2_arr [NREQ];
   logic           found;
   logic [IDW-1:0] win;
   logic [31:0]    alu_b;
   logic [31:0]    alu_y;

   always_comb begin
      for (int i = 0; i < NREQ; i++) begin
         op_arr[i]  = bus.req_op[6*i +: 6];
         rv1_arr[i] = bus.req_rv1[32*i +: 32];
         rv2_arr[i] = bus.req_rv2[32*i +: 32];
      end
   end

`ifdef ALU_ARB_RR_EN
   // Search starts just after the previous winner.
   always_comb begin
      int             idx;
      logic [IDW-1:0] idx_l;
      found = 1'b0;
      win   = '0;
      for (int k = 1; k <= NREQ; k++) begin
         idx   = (int'(last_q) + k) % NREQ;
         idx_l = IDW'(idx);
         if (!found && bus.req_valid[idx_l]) begin
            found = 1'b1;
            win   = idx_l;
         end
      end
   end
`else
   always_comb begin
      found = 1'b0;
      win   = '0;
      for (int i = NREQ-1; i >= 0; i--) begin
         if (bus.req_valid[i]) begin
            found = 1'b1;
            win   = IDW'(i);
         end
      end
   end
`endif

   assign alu_b = is_shift(op_q) ? {27'd0, rv2_q[4:0]} : rv2_q;

   alu32 u_alu (
      .op (op_q),
      .a  (rv1_q),
      .b  (alu_b),
      .y  (alu_y)
   );

   always_comb begin
      state_d       = state_q;
      op_d          = op_q;
      rv1_d         = rv1_q;
      rv2_d         = rv2_q;
      data_d        = data_q;
      id_d          = id_q;
      vld_d         = vld_q;
      err_d         = err_q;
      bus.req_ready = '0;
`ifdef ALU_ARB_RR_EN
      last_d        = last_q;
`endif
      case (state_q)
         IDLE: begin
            if (found) begin
               bus.req_ready = NREQ'(1) << win;
               op_d          = op_arr[win];
               rv1_d         = rv1_arr[win];
               rv2_d         = rv2_arr[win];
               id_d          = win;
               state_d       = EXEC;
`ifdef ALU_ARB_RR_EN
               last_d        = win;
`endif
            end
         end
         EXEC: begin
            data_d  = alu_y;
            err_d   = (op_q > OP_MAX);
            vld_d   = 1'b1;
            state_d = RESP;
         end
         RESP: begin
            if (bus.rsp_ready) begin
               vld_d   = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         op_q    <= '0;
         rv1_q   <= '0;
         rv2_q   <= '0;
         data_q  <= '0;
         id_q    <= '0;
         vld_q   <= 1'b0;
         err_q   <= 1'b0;
`ifdef ALU_ARB_RR_EN
         last_q  <= IDW'(NREQ-1);
`endif
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         rv1_q   <= rv1_d;
         rv2_q   <= rv2_d;
         data_q  <= data_d;
         id_q    <= id_d;
         vld_q   <= vld_d;
         err_q   <= err_d;
`ifdef ALU_ARB_RR_EN
         last_q  <= last_d;
`endif
      end
   end

   assign bus.rsp_valid = vld_q;
   assign bus.rsp_data  = data_q;
   assign bus.rsp_id    = id_q;
   assign bus.rsp_err   = err_q;
   assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized and directed bench for alu_arbiter against a behavioural model.
module tb_alu_arbiter;
   import alu_pkg::*;

   localparam int NREQ = 4;
   localparam int IDW  = 2;

   logic clk = 1'b0;
   logic reset_n;
   logic busy;

   alu_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

   alu_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus),
      .busy    (busy)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   logic [NREQ-1:0] vld;
   logic [5:0]      op [NREQ];
   logic [31:0]     ra [NREQ];
   logic [31:0]     rb [NREQ];
   int              last_m;

   task automatic apply();
      bus.req_valid = vld;
      for (int i = 0; i < NREQ; i++) begin
         bus.req_op[6*i +: 6]   = op[i];
         bus.req_rv1[32*i +: 32] = ra[i];
         bus.req_rv2[32*i +: 32] = rb[i];
      end
   endtask

   task automatic setreq(input int r, input logic [5:0] o, input logic [31:0] x, input logic [31:0] y);
      vld[r] = 1'b1;
      op[r]  = o;
      ra[r]  = x;
      rb[r]  = y;
      apply();
   endtask

   function automatic int pick(logic [NREQ-1:0] v);
`ifdef ALU_ARB_RR_EN
      for (int k = 1; k <= NREQ; k++) begin
         int idx;
         idx = (last_m + k) % NREQ;
         if (v[idx]) return idx;
      end
`else
      for (int i = 0; i < NREQ; i++)
         if (v[i]) return i;
`endif
      return -1;
   endfunction

   function automatic logic [31:0] ref_alu(logic [5:0] o, logic [31:0] a, logic [31:0] b);
      int sh;
      sh = int'(b % 32);
      case (o)
         6'd0:    return a + b;
         6'd1:    return a << sh;
         6'd2:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         6'd3:    return (a < b) ? 32'd1 : 32'd0;
         6'd4:    return a ^ b;
         6'd5:    return a >> sh;
         6'd6:    return a | b;
         6'd7:    return a & b;
         6'd8:    return 32'($signed(a) >>> sh);
         6'd9:    return a - b;
         default: return 32'd0;
      endcase
   endfunction

   // Entered and left just after a rising edge with the DUT idle.
   task automatic serve(input int stall, input bit drop, output logic [31:0] got, output int gid);
      int              w;
      int              t;
      logic [31:0]     ed;
      logic            ee;
      logic [NREQ-1:0] er;
      got = 'x;
      gid = -1;
      t   = 0;
      @(negedge clk);
      while (bus.req_ready === '0 && t < 20) begin
         @(negedge clk);
         t++;
      end
      w = pick(vld);
      tests++;
      if (t >= 20 || w < 0) begin
         fails++;
         $display("FAIL grant_wait: req_ready=%b after %0d cycles, valid=%b", bus.req_ready, t, vld);
         return;
      end
      er    = '0;
      er[w] = 1'b1;
      tests++;
      if (bus.req_ready !== er) begin
         fails++;
         $display("FAIL grant_onehot: req_ready=%b expected %b (valid=%b)", bus.req_ready, er, vld);
      end
      ed     = ref_alu(op[w], ra[w], rb[w]);
      ee     = (op[w] > 6'd9);
      last_m = w;
      @(posedge clk); #1;
      if (drop) begin
         vld[w] = 1'b0;
         apply();
      end
      bus.rsp_ready = (stall == 0);
      @(negedge clk);
      tests++;
      if ({bus.rsp_valid, busy, bus.req_ready} !== {1'b0, 1'b1, 4'b0000}) begin
         fails++;
         $display("FAIL exec_state: rsp_valid=%b busy=%b req_ready=%b expected 0 1 0000",
                  bus.rsp_valid, busy, bus.req_ready);
      end
      @(posedge clk); #1;
      @(negedge clk);
      tests++;
      if ({bus.rsp_valid, bus.rsp_data, bus.rsp_id, bus.rsp_err, bus.req_ready} !==
          {1'b1, ed, IDW'(w), ee, 4'b0000}) begin
         fails++;
         $display("FAIL response: valid=%b data=%h id=%0d err=%b ready=%b expected 1 %h %0d %b 0000 (op=%0d a=%h b=%h)",
                  bus.rsp_valid, bus.rsp_data, bus.rsp_id, bus.rsp_err, bus.req_ready, ed, w, ee, op[w], ra[w], rb[w]);
      end
      got = bus.rsp_data;
      gid = int'(bus.rsp_id);
      for (int s = 0; s < stall; s++) begin
         @(posedge clk); #1;
         @(negedge clk);
         tests++;
         if ({bus.rsp_valid, bus.rsp_data, bus.rsp_id, bus.rsp_err, busy, bus.req_ready} !==
             {1'b1, ed, IDW'(w), ee, 1'b1, 4'b0000}) begin
            fails++;
            $display("FAIL stall_hold[%0d]: valid=%b data=%h id=%0d err=%b busy=%b ready=%b expected 1 %h %0d %b 1 0000",
                     s, bus.rsp_valid, bus.rsp_data, bus.rsp_id, bus.rsp_err, busy, bus.req_ready, ed, w, ee);
         end
      end
      bus.rsp_ready = 1'b1;
      @(posedge clk); #1;
      tests++;
      if (bus.rsp_valid !== 1'b0) begin
         fails++;
         $display("FAIL rsp_clear: rsp_valid=%b expected 0", bus.rsp_valid);
      end
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      last_m  = NREQ-1;
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
   endtask

   task automatic test_reset();
      vld = '0;
      for (int i = 0; i < NREQ; i++) begin
         op[i] = '0; ra[i] = '0; rb[i] = '0;
      end
      apply();
      bus.rsp_ready = 1'b1;
      reset_n = 1'b0;
      last_m  = NREQ-1;
      repeat (2) @(posedge clk);
      #1;
      tests++;
      if ({bus.rsp_valid, bus.rsp_data, bus.rsp_id, bus.rsp_err, busy, bus.req_ready} !== '0) begin
         fails++;
         $display("FAIL reset_values: valid=%b data=%h id=%0d err=%b busy=%b ready=%b expected all 0",
                  bus.rsp_valid, bus.rsp_data, bus.rsp_id, bus.rsp_err, busy, bus.req_ready);
      end
      reset_n = 1'b1;
      @(negedge clk);
      tests++;
      if ({busy, bus.req_ready, bus.rsp_valid} !== '0) begin
         fails++;
         $display("FAIL idle_no_req: busy=%b ready=%b valid=%b expected 0", busy, bus.req_ready, bus.rsp_valid);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_directed();
      logic [31:0] d;
      int          id;
      logic [31:0] exp_d [5] = '{32'd12, 32'hFFFFFFFE, 32'hC0000000, 32'd1, 32'd0};
      int          exp_id [5] = '{0, 2, 2, 1, 1};
      logic [31:0] got_d [5];
      int          got_id [5];
      setreq(0, OP_ADD, 32'd5, 32'd7);                serve(0, 1, got_d[0], got_id[0]);
      setreq(2, OP_SUB, 32'd3, 32'd5);                serve(0, 1, got_d[1], got_id[1]);
      setreq(2, OP_SRA, 32'h80000000, 32'h21);        serve(0, 1, got_d[2], got_id[2]);
      setreq(1, OP_SLT, 32'hFFFFFFFF, 32'd1);         serve(0, 1, got_d[3], got_id[3]);
      setreq(1, OP_SLTU, 32'hFFFFFFFF, 32'd1);        serve(0, 1, got_d[4], got_id[4]);
      for (int i = 0; i < 5; i++) begin
         tests++;
         if (got_d[i] !== exp_d[i] || got_id[i] != exp_id[i]) begin
            fails++;
            $display("FAIL directed[%0d]: data=%h id=%0d expected %h %0d", i, got_d[i], got_id[i], exp_d[i], exp_id[i]);
         end
      end
      setreq(3, 6'd15, $urandom, $urandom);
      serve(10, 1, d, id);
      tests++;
      if (d !== 32'd0 || id != 3) begin
         fails++;
         $display("FAIL undef_op: data=%h id=%0d expected 0 3", d, id);
      end
   endtask

   task automatic test_all_valid();
      logic [31:0] d;
      int          id;
`ifdef ALU_ARB_RR_EN
      int          exp_seq [5] = '{0, 1, 2, 3, 0};
`else
      int          exp_seq [5] = '{0, 0, 0, 0, 0};
`endif
      do_reset();
      for (int r = 0; r < NREQ; r++) setreq(r, OP_ADD, 32'(r), 32'd100);
      for (int n = 0; n < 5; n++) begin
         serve(0, 0, d, id);
         tests++;
         if (id != exp_seq[n]) begin
            fails++;
            $display("FAIL all_valid_seq[%0d]: rsp_id=%0d expected %0d", n, id, exp_seq[n]);
         end
      end
   endtask

   task automatic test_reset_mid_exec();
      logic [31:0] d;
      int          id;
      do_reset();
      for (int r = 0; r < NREQ; r++) setreq(r, OP_XOR, 32'h1234 << r, 32'hFFFF);
      serve(0, 0, d, id);
      @(negedge clk);
      @(posedge clk); #1;
      @(negedge clk);
      tests++;
      if ({busy, bus.rsp_valid} !== 2'b10) begin
         fails++;
         $display("FAIL pre_reset_exec: busy=%b rsp_valid=%b expected 1 0", busy, bus.rsp_valid);
      end
      reset_n = 1'b0;
      #1;
      tests++;
      if ({busy, bus.rsp_valid} !== 2'b00) begin
         fails++;
         $display("FAIL async_reset: busy=%b rsp_valid=%b expected 0 0", busy, bus.rsp_valid);
      end
      @(posedge clk); #1;
      reset_n = 1'b1;
      last_m  = NREQ-1;
      serve(0, 1, d, id);
      tests++;
      if (id != 0) begin
         fails++;
         $display("FAIL post_reset_grant: rsp_id=%0d expected 0", id);
      end
      vld = '0;
      apply();
   endtask

   task automatic test_random();
      logic [31:0] d;
      int          id;
      int          r;
      for (int it = 0; it < 40; it++) begin
         for (int k = 0; k < NREQ; k++)
            if (!vld[k] && $urandom_range(0, 1) == 1)
               setreq(k, 6'($urandom_range(0, 12)), $urandom, $urandom);
         if (vld == '0) setreq(int'($urandom_range(0, NREQ-1)), 6'($urandom_range(0, 12)), $urandom, $urandom);
         if ($urandom_range(0, 3) == 0 && $countones(vld) > 1) begin
            r = int'($urandom_range(0, NREQ-1));
            if (vld[r]) begin
               vld[r] = 1'b0;
               apply();
            end
         end
         serve(int'($urandom_range(0, 2)), 1, d, id);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_directed();
      test_all_valid();
      test_reset_mid_exec();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Sequential front-end that shares one `alu32` datapath between up to NREQ requesters (fetch/execute units, address generator, test port). Requests are accepted with a valid/ready handshake and issued to the ALU one at a time, with round-robin or fixed-priority selection. The result returns tagged with the requester index on a registered response channel. The block also configures the ALU operands by masking shift amounts to 5 bits.

## Interface
- NREQ, 4, number of requesters (2..4)
- IDW, 2, requester-index width, must be ≥ clog2(NREQ)
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  NREQ  per-requester request valid
- req_ready  out  NREQ  one-hot accept strobe
- req_op  in  6*NREQ  op code, slice i = [6i+5:6i]
- req_rv1  in  32*NREQ  operand 1, slice i = [32i+31:32i]
- req_rv2  in  32*NREQ  operand 2, same slicing
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumer ready
- rsp_id  out  IDW  index of the requester that owns the response
- rsp_data  out  32  ALU result
- rsp_err  out  1  op code was undefined
- busy  out  1  high in every state except IDLE

## Operation
- FSM has three states: IDLE → EXEC → RESP → IDLE.
- IDLE: if any req_valid bit is set, pick a winner and drive req_ready[winner]=1 combinationally in the same cycle. On the clock edge, latch op, rv1, rv2 and the winner id, then go to EXEC. No request pending: stay in IDLE with req_ready=0.
- req_ready is 0 in EXEC and RESP. A requester holds valid, op and operands stable until it sees ready. A requester may drop valid before it is granted; that is legal and causes no grant.
- EXEC: the latched operands drive `alu32`. For SLL, SRL and SRA, rv2 is masked to rv2[4:0] before it reaches the ALU. At the edge, register the result into rsp_data, set rsp_err = (op > 9), set rsp_valid=1, and go to RESP.
- RESP: hold rsp_valid, rsp_data, rsp_id and rsp_err stable until rsp_ready=1. On the handshake edge, clear rsp_valid and go to IDLE.
- Op codes:
  - ADD=0, SLL=1, SLT=2, SLTU=3, XOR=4, SRL=5, OR=6, AND=7, SRA=8, SUB=9.
  - Any other code gives rsp_data=0 and rsp_err=1.
- Arithmetic: 32-bit with wrap-around and no carry or overflow output. SLT is signed and SLTU is unsigned.
- Round-robin pointer `last`:
  - The search order starts at last+1 mod NREQ.
  - `last` updates only on an accept edge.
  - Reset value is NREQ-1, so requester 0 wins first.

## Timing
- Reset (asynchronous, active-low): state=IDLE, req_ready=0, rsp_valid=0, rsp_data=0, rsp_id=0, rsp_err=0, busy=0, last=NREQ-1.
- Reset asserted mid-operation discards the in-flight op and any pending response. No partial response is ever emitted.
- Latency: accept edge at the end of cycle N gives rsp_valid=1 in cycle N+2.
- Throughput: at most one op every 3 cycles. No new accept happens in the cycle of the response handshake.
- rsp_ready held low stalls indefinitely. All requests wait, with their req_ready held at 0.
- Simultaneous valid on every requester: exactly one bit of req_ready is set per accept. No grant is ever issued outside IDLE.
- rsp_ready=1 outside RESP has no effect.

## Configuration
- ALU_ARB_RR_EN defined: round-robin selection as described above.
- ALU_ARB_RR_EN undefined: fixed priority, where the lowest index wins. The `last` register is not built, and requester 0 can starve the others.

## Structure
- Package `alu_pkg` holds:
  - the op-code localparams (ADD…SUB, 6-bit);
  - the FSM state encoding (IDLE=2'd0, EXEC=2'd1, RESP=2'd2);
  - the constant OP_MAX=9 used for error detection.
- Sub-module: a single instance of `alu32` as the datapath. Operand latches, masking, FSM and arbitration are inline.
- Expected size is about 150–250 lines of RTL.

## Test plan
- Requester 0: ADD with rv1=5, rv2=7, rsp_ready=1 → req_ready=4'b0001 for one cycle; rsp_valid=1 two cycles later with rsp_data=12, rsp_id=0, rsp_err=0.
- Requester 2: SUB with rv1=3, rv2=5 → rsp_data=32'hFFFFFFFE. Then SRA with rv1=32'h80000000, rv2=32'h21 → rsp_data=32'hC0000000, proving the shift is masked to 1.
- SLT with rv1=32'hFFFFFFFF, rv2=1 → rsp_data=1. SLTU with the same operands → rsp_data=0.
- All 4 requesters valid continuously with ALU_ARB_RR_EN defined → rsp_id sequence 0,1,2,3,0. With the macro undefined → rsp_id 0,0,0,0.
- Undefined op 6'd15 → rsp_data=0, rsp_err=1. Hold rsp_ready=0 for 10 cycles → outputs stable, busy=1, req_ready=0 throughout.
- Assert reset_n=0 during EXEC → rsp_valid=0 and busy=0 immediately. After release, with 4 requests pending, the first grant goes to requester 0.
